// File: rtl/debounce_pulse_pkg.sv
// Shared constants and types for the push-button debouncer.
package debounce_pulse_pkg;

  // Fewer than two samples cannot tell a bounce from a real edge.
  localparam int SAMPLES_MIN = 2;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } btn_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One button lane: 2-flop synchroniser, tick-rate sample history,
// RELEASED/PRESSED state machine and registered edge pulses.
module debounce_channel
  import debounce_pulse_pkg::*;
#(
  parameter int SAMPLES = 4
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic tick,
  input  logic btn_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int S = (SAMPLES < SAMPLES_MIN) ? SAMPLES_MIN : SAMPLES;

  logic [1:0]   sync_q;
  logic [S-1:0] hist_q;
  logic [S-1:0] hist_nxt;
  btn_state_e   state_q;
  btn_state_e   state_nxt;
  logic         rise;
  logic         fall;

  // History as it will look once the current tick has shifted in.
  assign hist_nxt = {hist_q[S-2:0], sync_q[1]};

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge CLOCK) begin
    if (RESET) sync_q <= '0;
    else       sync_q <= {sync_q[0], btn_raw};
  end

  // Shift one synchronised sample in per tick; hold between ticks.
  always_ff @(posedge CLOCK) begin
    if (RESET)     hist_q <= '0;
    else if (tick) hist_q <= hist_nxt;
  end

  // State register.
  always_ff @(posedge CLOCK) begin
    if (RESET) state_q <= RELEASED;
    else       state_q <= state_nxt;
  end

  // Change state only on a tick with a uniform history; mixed histories hold.
  always_comb begin
    state_nxt = state_q;
    if (tick) begin
      case (state_q)
        RELEASED: if (&hist_nxt) state_nxt = PRESSED;
        PRESSED:  if (~|hist_nxt) state_nxt = RELEASED;
        default:  state_nxt = RELEASED;
      endcase
    end
  end

  // Level mirrors the state; edges are decoded from the pending transition.
  always_comb begin
    level = (state_q == PRESSED);
    rise  = (state_q == RELEASED) && (state_nxt == PRESSED);
    fall  = (state_q == PRESSED)  && (state_nxt == RELEASED);
  end

  // Register pulses so they line up with the first cycle of the new level.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= rise;
      release_pulse <= fall;
    end
  end

endmodule

// File: rtl/debounce_pulse.sv
// WIDTH-channel push-button debouncer clocked by SLOW rising edges,
// with press/release pulses and a wrapping press counter.
module debounce_pulse
  import debounce_pulse_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int SAMPLES = 4,
  parameter int CNT_W   = 8
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             SLOW,
  input  logic [WIDTH-1:0] BTN_IN,
  output logic [WIDTH-1:0] BTN_LEVEL,
  output logic [WIDTH-1:0] BTN_PRESS,
  output logic [WIDTH-1:0] BTN_RELEASE,
  output logic [CNT_W-1:0] PRESS_COUNT
);

  localparam int PC_W = $clog2(WIDTH + 1);

  logic            slow_q;
  logic            tick;
  logic [PC_W-1:0] press_pop;

  // SLOW is already in the CLOCK domain; one flop is enough for edge detect.
  always_ff @(posedge CLOCK) begin
    if (RESET) slow_q <= 1'b0;
    else       slow_q <= SLOW;
  end

  assign tick = SLOW & ~slow_q;

  debounce_channel #(.SAMPLES(SAMPLES)) u_ch [WIDTH-1:0] (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .tick          (tick),
    .btn_raw       (BTN_IN),
    .level         (BTN_LEVEL),
    .press_pulse   (BTN_PRESS),
    .release_pulse (BTN_RELEASE)
  );

  // Number of channels pressing this cycle.
  always_comb begin
    press_pop = '0;
    for (int i = 0; i < WIDTH; i++) press_pop = press_pop + PC_W'(BTN_PRESS[i]);
  end

  // Accumulate presses one cycle after the pulses; wraps naturally.
  always_ff @(posedge CLOCK) begin
    if (RESET) PRESS_COUNT <= '0;
    else       PRESS_COUNT <= PRESS_COUNT + CNT_W'(press_pop);
  end

endmodule

// File: tb/tb_debounce_pulse.sv
// Directed bench for debounce_pulse: WIDTH=4, SAMPLES=4, CNT_W=8, SLOW period 8.
module tb_debounce_pulse;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             CLOCK = 1'b0;
  logic             RESET;
  logic             SLOW = 1'b0;
  logic [WIDTH-1:0] BTN_IN;
  logic [WIDTH-1:0] BTN_LEVEL;
  logic [WIDTH-1:0] BTN_PRESS;
  logic [WIDTH-1:0] BTN_RELEASE;
  logic [CNT_W-1:0] PRESS_COUNT;

  int checks = 0;
  int errors = 0;
  int npress [WIDTH];
  int nrel   [WIDTH];
  int both_hi = 0;

  debounce_pulse #(.WIDTH(WIDTH), .SAMPLES(4), .CNT_W(CNT_W)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .SLOW        (SLOW),
    .BTN_IN      (BTN_IN),
    .BTN_LEVEL   (BTN_LEVEL),
    .BTN_PRESS   (BTN_PRESS),
    .BTN_RELEASE (BTN_RELEASE),
    .PRESS_COUNT (PRESS_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  // SLOW: 4 cycles low, 4 high, toggled on falling CLOCK edges.
  initial begin
    forever begin
      repeat (4) @(negedge CLOCK);
      SLOW = ~SLOW;
    end
  end

  // Pulse tallies for the bounce and overlap checks.
  initial begin
    for (int i = 0; i < WIDTH; i++) begin npress[i] = 0; nrel[i] = 0; end
    forever begin
      @(negedge CLOCK);
      for (int i = 0; i < WIDTH; i++) begin
        if (BTN_PRESS[i] === 1'b1)   npress[i]++;
        if (BTN_RELEASE[i] === 1'b1) nrel[i]++;
      end
      if ((BTN_PRESS & BTN_RELEASE) !== '0) both_hi++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press on a SLOW rise; returns one cycle after the pulse (count settled).
  task automatic do_press(input logic [WIDTH-1:0] mask);
    @(posedge SLOW);
    BTN_IN = BTN_IN | mask;
    repeat (4) @(posedge SLOW);
    @(negedge CLOCK);
    @(negedge CLOCK);
  endtask

  task automatic do_release(input logic [WIDTH-1:0] mask);
    @(posedge SLOW);
    BTN_IN = BTN_IN & ~mask;
    repeat (4) @(posedge SLOW);
    @(negedge CLOCK);
    @(negedge CLOCK);
  endtask

  initial begin
    logic [WIDTH-1:0] acc;
    int p1, r1;
    RESET  = 1'b1;
    BTN_IN = '0;

    // Reset state
    @(negedge CLOCK);
    chk("rst_level", 32'(BTN_LEVEL), 0);
    chk("rst_count", 32'(PRESS_COUNT), 0);
    chk("rst_pulses", 32'(BTN_PRESS | BTN_RELEASE), 0);
    @(negedge CLOCK);
    RESET = 1'b0;

    // Idle 100 cycles
    acc = '0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLOCK);
      acc = acc | BTN_LEVEL | BTN_PRESS | BTN_RELEASE;
    end
    chk("idle_quiet", 32'(acc), 0);
    chk("idle_count", 32'(PRESS_COUNT), 0);

    // Clean press on channel 0
    @(posedge SLOW);
    BTN_IN[0] = 1'b1;
    repeat (4) @(posedge SLOW);
    chk("p0_before_4th_tick", 32'(BTN_LEVEL), 0);
    @(negedge CLOCK);
    chk("p0_level", 32'(BTN_LEVEL), 32'h1);
    chk("p0_press", 32'(BTN_PRESS), 32'h1);
    chk("p0_count_lag", 32'(PRESS_COUNT), 0);
    @(negedge CLOCK);
    chk("p0_press_1cyc", 32'(BTN_PRESS), 0);
    chk("p0_count", 32'(PRESS_COUNT), 1);

    // Clean release on channel 0
    @(posedge SLOW);
    BTN_IN[0] = 1'b0;
    repeat (4) @(posedge SLOW);
    chk("r0_before", 32'(BTN_LEVEL), 32'h1);
    @(negedge CLOCK);
    chk("r0_level", 32'(BTN_LEVEL), 0);
    chk("r0_release", 32'(BTN_RELEASE), 32'h1);
    chk("r0_no_press", 32'(BTN_PRESS), 0);
    @(negedge CLOCK);
    chk("r0_release_1cyc", 32'(BTN_RELEASE), 0);
    chk("r0_count", 32'(PRESS_COUNT), 1);

    // Bounce on channel 1: toggles every tick, then settles low
    #1;
    p1 = npress[1];
    r1 = nrel[1];
    @(posedge SLOW);
    BTN_IN[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge SLOW);
      BTN_IN[1] = ~BTN_IN[1];
    end
    BTN_IN[1] = 1'b0;
    repeat (6) @(posedge SLOW);
    #1;
    chk("bnc_level", 32'(BTN_LEVEL), 0);
    chk("bnc_press", 32'(npress[1] - p1), 0);
    chk("bnc_release", 32'(nrel[1] - r1), 0);
    chk("bnc_count", 32'(PRESS_COUNT), 1);

    // All four channels together
    @(posedge SLOW);
    BTN_IN = 4'hF;
    repeat (4) @(posedge SLOW);
    @(negedge CLOCK);
    chk("all_press", 32'(BTN_PRESS), 32'hF);
    chk("all_level", 32'(BTN_LEVEL), 32'hF);
    @(negedge CLOCK);
    chk("all_press_1cyc", 32'(BTN_PRESS), 0);
    chk("all_count", 32'(PRESS_COUNT), 5);
    @(posedge SLOW);
    BTN_IN = 4'h0;
    repeat (4) @(posedge SLOW);
    @(negedge CLOCK);
    chk("all_release", 32'(BTN_RELEASE), 32'hF);
    chk("all_rel_no_press", 32'(BTN_PRESS), 0);
    @(negedge CLOCK);
    chk("all_rel_count", 32'(PRESS_COUNT), 5);

    // Preload to 254: 62 four-way rounds (+248) and one single press
    for (int k = 0; k < 62; k++) begin
      do_press(4'hF);
      do_release(4'hF);
    end
    do_press(4'h4);
    do_release(4'h4);
    chk("pre_254", 32'(PRESS_COUNT), 254);
    do_press(4'h4);
    chk("wrap_255", 32'(PRESS_COUNT), 255);
    do_release(4'h4);
    do_press(4'h4);
    chk("wrap_0", 32'(PRESS_COUNT), 0);
    do_release(4'h4);
    do_press(4'h4);
    chk("wrap_1", 32'(PRESS_COUNT), 1);
    do_release(4'h4);

    // Reset mid-debounce after 2 of 4 ticks with channel 0 held
    @(posedge SLOW);
    BTN_IN[0] = 1'b1;
    repeat (2) @(posedge SLOW);
    @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    chk("mid_rst_level", 32'(BTN_LEVEL), 0);
    chk("mid_rst_count", 32'(PRESS_COUNT), 0);
    repeat (4) @(posedge SLOW);
    chk("mid_rst_no_early", 32'(BTN_LEVEL), 0);
    @(negedge CLOCK);
    chk("mid_rst_press", 32'(BTN_PRESS), 32'h1);
    @(negedge CLOCK);
    chk("mid_rst_count1", 32'(PRESS_COUNT), 1);

    // Reset landing on a tick cycle while pressed and held
    @(posedge SLOW);
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    chk("tick_rst_level", 32'(BTN_LEVEL), 0);
    chk("tick_rst_count", 32'(PRESS_COUNT), 0);
    repeat (4) @(posedge SLOW);
    chk("tick_rst_no_early", 32'(BTN_LEVEL), 0);
    @(negedge CLOCK);
    chk("tick_rst_press", 32'(BTN_PRESS), 32'h1);
    chk("tick_rst_level1", 32'(BTN_LEVEL), 32'h1);

    #1;
    chk("press_release_overlap", 32'(both_hi), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
